// File: rtl/twowire_host_connect_seq.sv
// twowire_host_connect_seq
//   Host-side Two-Wire Debug Connect sequencer. On an accepted start it drives
//   PREAMBLE_LEN zero bits, a 64-bit LFSR signature (seed 6'h29), then the
//   4-bit multidrop address followed by its complement. All outputs are
//   registered, so each wire bit appears one cycle after the decision.
//
//   Optional build macro: TWD_HOST_CONNECT_ABORT_EN adds the abort input.
//
// Ports
//   dck      debug clock, all logic on posedge
//   drst     synchronous reset, active-high
//   start    request a Connect sequence (accepted only while ready)
//   target   multidrop address, sampled on accept
//   abort    (macro only) cancel the sequence in flight, back to IDLE
//   ready    high in IDLE
//   busy     high while the sequence is on the wire
//   done     one-cycle pulse after the last address bit
//   dio_out  registered DIO data
//   dio_oe   registered DIO output enable
module twowire_host_connect_seq #(
  parameter int PREAMBLE_LEN = 8
) (
  input  logic       dck,
  input  logic       drst,
  input  logic       start,
  input  logic [3:0] target,
`ifdef TWD_HOST_CONNECT_ABORT_EN
  input  logic       abort,
`endif
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       dio_out,
  output logic       dio_oe
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SIG, S_ADDR, S_DONE} state_t;

  localparam logic [5:0] LFSR_SEED = 6'h29;
  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [5:0] lfsr, lfsr_d;
  logic [3:0] addr_q, addr_d;
  logic       ready_d, busy_d, done_d, dio_out_d, dio_oe_d;
  logic [1:0] kidx;
  logic       on_wire;

  assign on_wire = (state == S_PRE) || (state == S_SIG) || (state == S_ADDR);

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    addr_d  = addr_q;
    case (state)
      S_IDLE: if (start) begin
        state_d = S_PRE;
        addr_d  = target;
        lfsr_d  = LFSR_SEED;
      end
      S_PRE:  if (cnt == PRE_LAST) state_d = S_SIG;
      S_SIG: begin
        lfsr_d = {lfsr[4:0], ^(lfsr & 6'h30)};
        if (cnt == 8'd63) state_d = S_ADDR;
      end
      S_ADDR: if (cnt == 8'd7) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef TWD_HOST_CONNECT_ABORT_EN
    // Abort only matters while driving; it wins over any transition.
    if (abort && on_wire) state_d = S_IDLE;
`endif

    // Counter restarts at every state change and only runs while driving.
    if (state_d != state || state_d == S_IDLE || state_d == S_DONE) cnt_d = 8'd0;
    else                                                               cnt_d = cnt + 8'd1;

    // Address phase: k=0..3 -> a[3-k], k=4..7 -> ~a[7-k]; both are a[~k[1:0]].
    kidx = ~cnt_d[1:0];

    // Outputs are computed from the next state so they register with it.
    ready_d   = (state_d == S_IDLE);
    done_d    = (state_d == S_DONE);
    busy_d    = 1'b0;
    dio_oe_d  = 1'b0;
    dio_out_d = 1'b0;
    case (state_d)
      S_PRE:  begin busy_d = 1'b1; dio_oe_d = 1'b1; end
      S_SIG:  begin busy_d = 1'b1; dio_oe_d = 1'b1; dio_out_d = lfsr_d[5]; end
      S_ADDR: begin busy_d = 1'b1; dio_oe_d = 1'b1; dio_out_d = addr_d[kidx] ^ cnt_d[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge dck) begin
    if (drst) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      lfsr    <= LFSR_SEED;
      addr_q  <= 4'd0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      dio_out <= 1'b0;
      dio_oe  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      lfsr    <= lfsr_d;
      addr_q  <= addr_d;
      ready   <= ready_d;
      busy    <= busy_d;
      done    <= done_d;
      dio_out <= dio_out_d;
      dio_oe  <= dio_oe_d;
    end
  end

endmodule

// File: tb/tb_twowire_host_connect_seq.sv
module tb_twowire_host_connect_seq;
  localparam int P = 8;

  logic       dck = 1'b0;
  logic       drst, start, abort_r;
  logic [3:0] target;
  logic       ready, busy, done, dio_out, dio_oe;

  int errs = 0;
  int checks = 0;
  logic sig [0:63];
  logic wire_q [$];

  always #5 dck = ~dck;

  twowire_host_connect_seq #(.PREAMBLE_LEN(P)) dut (
    .dck(dck), .drst(drst), .start(start), .target(target),
`ifdef TWD_HOST_CONNECT_ABORT_EN
    .abort(abort_r),
`endif
    .ready(ready), .busy(busy), .done(done), .dio_out(dio_out), .dio_oe(dio_oe)
  );

  task automatic step();
    @(posedge dck); #1;
  endtask

  // Signature as a bit sequence: b[n+6] = b[n] ^ b[n+1], seeded 1,0,1,0,0,1.
  task automatic init_sig();
    int b [0:69];
    b[0] = 1; b[1] = 0; b[2] = 1; b[3] = 0; b[4] = 0; b[5] = 1;
    for (int n = 0; n < 64; n++) b[n+6] = b[n] ^ b[n+1];
    for (int n = 0; n < 64; n++) sig[n] = b[n][0];
  endtask

  // Expected wire bit on cycle i after accept (i = 1 .. P+72).
  function automatic logic exp_bit(input logic [3:0] t, input int i);
    int k;
    if (i <= P) return 1'b0;
    if (i <= P + 64) return sig[i-P-1];
    k = i - P - 65;
    if (k < 4) return t[3-k];
    return ~t[7-k];
  endfunction

  task automatic check_idle(input string name);
    logic [4:0] got;
    got = {ready, busy, done, dio_oe, dio_out};
    checks++;
    if (got !== 5'b10000) begin
      errs++;
      $display("FAIL %s {ready,busy,done,oe,out} got=%b exp=10000", name, got);
    end
  endtask

  // Accept on the next edge with target t, then check every cycle to done.
  task automatic run_seq(input logic [3:0] t, input bit hold);
    logic [4:0] got, exp;
    start = 1'b1; target = t;
    wire_q.delete();
    for (int i = 1; i <= P + 73; i++) begin
      step();
      if (!hold) start = 1'b0;
      abort_r = 1'b0;
      target = 4'($urandom);
      exp = (i <= P + 72) ? {4'b0101, exp_bit(t, i)} : 5'b00100;
      got = {ready, busy, done, dio_oe, dio_out};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL seq t=%h cyc=%0d {ready,busy,done,oe,out} got=%b exp=%b", t, i, got, exp);
      end
      if (i <= P + 72) wire_q.push_back(dio_out);
    end
  endtask

  // Reference connect monitor: returns the wire index where connect fires, or -1.
  function automatic int monitor(input logic [3:0] md);
    int L;
    bit ok;
    L = P + 72;
    for (int j = L - 1; j < wire_q.size(); j++) begin
      ok = 1;
      for (int n = 0; n < L; n++) begin
        logic e;
        if (n < P) e = 1'b0;
        else if (n < P + 64) e = sig[n-P];
        else if (n < P + 68) e = md[3-(n-P-64)];
        else e = ~md[7-(n-P-64)];
        if (wire_q[j-L+1+n] !== e) ok = 0;
      end
      if (ok) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    drst = 1'b1; start = 1'b0; abort_r = 1'b0; target = 4'h0;
    repeat (3) step();
    check_idle("reset");
    drst = 1'b0;
    step();
    check_idle("post_reset_idle");
  endtask

  task automatic test_connect();
    run_seq(4'h5, 1'b0);
    step(); check_idle("idle_after_5");
    repeat (3) begin
      run_seq(4'($urandom), 1'b0);
      step(); check_idle("idle_after_rand");
    end
  endtask

  task automatic test_monitor();
    int r;
    run_seq(4'h5, 1'b0);
    step(); check_idle("idle_mon");
    r = monitor(4'h5);
    checks++;
    if (r !== P + 71) begin errs++; $display("FAIL monitor_match got=%0d exp=%0d", r, P + 71); end
    r = monitor(4'h6);
    checks++;
    if (r !== -1) begin errs++; $display("FAIL monitor_nomatch got=%0d exp=-1", r); end
  endtask

  task automatic test_start_held();
    run_seq(4'hA, 1'b1);
    step(); check_idle("held_idle_gap");
    run_seq(4'h3, 1'b0);
    step(); check_idle("held_after_second");
    step(); check_idle("held_no_third");
  endtask

  task automatic test_reset_mid();
    logic [3:0] t;
    t = 4'($urandom);
    start = 1'b1; target = t;
    for (int i = 1; i <= P + 30; i++) begin
      step();
      start = 1'b0;
      checks++;
      if (dio_out !== exp_bit(t, i) || dio_oe !== 1'b1) begin
        errs++;
        $display("FAIL mid_seq cyc=%0d out=%b exp=%b oe=%b", i, dio_out, exp_bit(t, i), dio_oe);
      end
    end
    drst = 1'b1;
    step();
    drst = 1'b0;
    check_idle("reset_mid");
    for (int i = 0; i < 4; i++) begin step(); check_idle("reset_mid_quiet"); end
    run_seq(4'hC, 1'b0);
    step(); check_idle("after_reset_restart");
  endtask

`ifdef TWD_HOST_CONNECT_ABORT_EN
  task automatic test_abort();
    start = 1'b1; target = 4'h9;
    for (int i = 1; i <= P + 67; i++) begin step(); start = 1'b0; end
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    check_idle("abort_addr");
    for (int i = 0; i < 4; i++) begin step(); check_idle("abort_quiet"); end
    abort_r = 1'b1;
    run_seq(4'h7, 1'b0);
    step(); check_idle("abort_start_idle");
  endtask
`endif

  initial begin
    init_sig();
    test_reset();
    test_connect();
    test_monitor();
    test_start_held();
    test_reset_mid();
`ifdef TWD_HOST_CONNECT_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
